// File: rtl/fifo_async_read_ctrl.sv
// Read-domain controller of the async circular FIFO: write-pointer synchroniser, binary/Gray read
// pointers, empty/almost-empty/level flags and a registered first-word-fall-through output stage.
module fifo_async_read_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned PTR_WIDTH     = 4,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                 read_clk,
    input  logic                 rst_in,
    input  logic [PTR_WIDTH-1:0] wptr_g_in,
    output logic [PTR_WIDTH-1:0] rptr_g_out,
    output logic [PTR_WIDTH-2:0] raddr_out,
    input  logic [WIDTH-1:0]     rdata_mem_in,
    output logic [WIDTH-1:0]     dout_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 empty_out,
    output logic                 aempty_out,
    output logic [PTR_WIDTH-1:0] level_out
);

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PTR_WIDTH-1:0] wptr_g_sync1_q, wptr_g_sync2_q;
    logic [PTR_WIDTH-1:0] rptr_b_q, rptr_b_d;
    logic [PTR_WIDTH-1:0] rptr_g_q, rptr_g_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 aempty_q, aempty_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [PTR_WIDTH-1:0] wptr_b_sync;
    logic                 pop_mem;

    always_comb begin
        wptr_b_sync = gray2bin(wptr_g_sync2_q);
        // Refill the output stage whenever it is empty or its word leaves this cycle.
        pop_mem     = !empty_q && (!valid_q || ready_in);
        rptr_b_d    = rptr_b_q + {{(PTR_WIDTH-1){1'b0}}, pop_mem};
        rptr_g_d    = (rptr_b_d >> 1) ^ rptr_b_d;
        empty_d     = (rptr_g_d == wptr_g_sync2_q);
        level_d     = wptr_b_sync - rptr_b_d;
        aempty_d    = (32'(level_d) <= AEMPTY_THRESH);
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (pop_mem) begin
            dout_d  = rdata_mem_in;
            valid_d = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge read_clk or posedge rst_in) begin
        if (rst_in) begin
            wptr_g_sync1_q <= '0;
            wptr_g_sync2_q <= '0;
            rptr_b_q       <= '0;
            rptr_g_q       <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            aempty_q       <= 1'b1;
            valid_q        <= 1'b0;
            dout_q         <= '0;
        end else begin
            wptr_g_sync1_q <= wptr_g_in;
            wptr_g_sync2_q <= wptr_g_sync1_q;
            rptr_b_q       <= rptr_b_d;
            rptr_g_q       <= rptr_g_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            aempty_q       <= aempty_d;
            valid_q        <= valid_d;
            dout_q         <= dout_d;
        end
    end

    assign rptr_g_out = rptr_g_q;
    assign raddr_out  = rptr_b_q[PTR_WIDTH-2:0];
    assign dout_out   = dout_q;
    assign valid_out  = valid_q;
    assign empty_out  = empty_q;
    assign aempty_out = aempty_q;
    assign level_out  = level_q;

endmodule
